mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter MAXWAIT, default 3: maximum consecutive data grants while a fetch is pending.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 f_req  input  1  fetch request; held until f_gnt.
REQ-006 f_addr  input  XLEN  fetch address (pc).
REQ-007 flush  input  1  branch taken; kill in-flight fetch response.
REQ-008 d_req  input  1  load/store request; held until d_gnt.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  XLEN  data address.
REQ-011 d_wdata  input  XLEN  store data.
REQ-012 mem_ready  input  1  memory completes current access.
REQ-013 mem_rdata  input  XLEN  read data, valid when mem_ready=1.
REQ-014 f_gnt / d_gnt  output  1 each  one-cycle grant pulse.
REQ-015 f_valid / d_valid  output  1 each  one-cycle response pulse.
REQ-016 f_rdata / d_rdata  output  XLEN each  response data, valid with the matching valid pulse.
REQ-017 mem_req, mem_we  output  1 each  memory access strobe and write enable.
REQ-018 mem_addr, mem_wdata  output  XLEN each  memory address and write data.
REQ-019 busy  output  1  high when state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, F_WAIT and D_WAIT; all outputs SHALL be registered.
REQ-021 Arbitration SHALL occur only at edges where state=IDLE and f_req|d_req=1.
REQ-022 Priority SHALL be d_req over f_req, except that fetch SHALL win when f_req=1 and streak==MAXWAIT.
REQ-023 The streak counter (ceil(log2(MAXWAIT+1)) bits) SHALL increment on a data grant when f_req=1, clear on a fetch grant, hold otherwise, and never exceed MAXWAIT.
REQ-024 On a grant edge: gnt pulses for one cycle; mem_req=1; mem_addr/mem_we/mem_wdata latch the winner's values (mem_we=0 for fetch); state moves to F_WAIT or D_WAIT.
REQ-025 mem_req and the mem_* fields SHALL be held stable until the edge where mem_ready=1 is sampled.
REQ-026 At that edge: mem_req←0; the matching valid pulses for one cycle; rdata←mem_rdata; state←IDLE.
REQ-027 d_valid SHALL also pulse for stores as an acknowledge; d_rdata then equals mem_rdata.
REQ-028 Minimum transaction: request sampled at edge N, grant in cycle N+1, mem_ready at edge N+1 at earliest, valid in cycle N+2, next arbitration at edge N+2.
REQ-029 flush=1 sampled at an edge where state=F_WAIT, or at a fetch-grant edge, SHALL set a kill flag; the access still completes on memory, but f_valid SHALL stay 0 and f_rdata SHALL hold its value.
REQ-030 The kill flag SHALL clear on completion; flush in IDLE or D_WAIT SHALL have no effect.
REQ-031 mem_ready=1 in IDLE SHALL be ignored.
REQ-032 Data responses SHALL never be affected by flush.
REQ-033 A requester dropping req before its grant SHALL simply not be granted; no error is raised.
REQ-034 Only one access SHALL be outstanding at any time.

Reset
REQ-035 reset=0 SHALL immediately force state=IDLE, streak=0, kill=0, and all outputs to 0 (including rdata and mem_* fields).
REQ-036 reset asserted mid-access SHALL abandon the access with no valid pulse; after release, arbitration restarts from IDLE.

Verification
REQ-037 f_req=1 with f_addr=0x40 and mem_ready returned 1 cycle after mem_req with rdata=0x00500093 -> f_gnt in cycle 1, mem_addr=0x40, mem_we=0, f_valid with f_rdata=0x00500093, busy low afterwards.
REQ-038 f_req and d_req both asserted, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> d_gnt first with mem_we=1 and mem_wdata=0xDEADBEEF; fetch granted after d_valid.
REQ-039 d_req held continuously with f_req pending, MAXWAIT=3 -> exactly 3 data grants, then f_gnt, then streak restarts from 0.
REQ-040 Fetch in F_WAIT, flush pulsed, mem_ready delayed 4 cycles -> no f_valid, f_rdata unchanged, next fetch returns normally.
REQ-041 reset driven 0 during D_WAIT -> outputs 0 immediately without a clock; no d_valid; after release, a new d_req is served normally.
REQ-042 mem_ready held at 1 permanently with alternating requests -> one valid per grant, never two accesses outstanding.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: an instruction fetch port and a load/store port
// share one memory. One access is outstanding at a time; data wins ties unless
// fetch has been starved for MAXWAIT back-to-back data grants.
module mem_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MAXWAIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            f_req,
  input  logic [XLEN-1:0] f_addr,
  input  logic            flush,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            f_gnt,
  output logic            d_gnt,
  output logic            f_valid,
  output logic            d_valid,
  output logic [XLEN-1:0] f_rdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            busy
);

  localparam int unsigned SW = (MAXWAIT < 1) ? 1 : $clog2(MAXWAIT + 1);
  localparam logic [SW-1:0] StreakMax = SW'(MAXWAIT);

  typedef enum logic [1:0] {StIdle, StFWait, StDWait} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              kill_q, kill_d;
  logic              f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
  logic              f_valid_q, f_valid_d, d_valid_q, d_valid_d;
  logic [XLEN-1:0]   f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              fetch_starved;

  assign fetch_starved = f_req && (streak_q == StreakMax);

  // Next-state: arbitrate in idle, wait for mem_ready otherwise.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    kill_d      = kill_q;
    f_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    f_valid_d   = 1'b0;
    d_valid_d   = 1'b0;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (d_req && !fetch_starved) begin
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          state_d     = StDWait;
          // Only count data grants that actually made fetch wait.
          if (f_req && (streak_q < StreakMax)) streak_d = streak_q + SW'(1);
        end else if (f_req) begin
          f_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = f_addr;
          mem_wdata_d = '0;
          state_d     = StFWait;
          streak_d    = '0;
          kill_d      = flush;
        end
      end
      StFWait: begin
        if (flush) kill_d = 1'b1;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          kill_d    = 1'b0;
          // A flush on the completing edge still kills the response.
          if (!(kill_q || flush)) begin
            f_valid_d = 1'b1;
            f_rdata_d = mem_rdata;
          end
        end
      end
      StDWait: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          d_valid_d = 1'b1;
          d_rdata_d = mem_rdata;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      streak_q    <= '0;
      kill_q      <= 1'b0;
      f_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
      f_valid_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      kill_q      <= kill_d;
      f_gnt_q     <= f_gnt_d;
      d_gnt_q     <= d_gnt_d;
      f_valid_q   <= f_valid_d;
      d_valid_q   <= d_valid_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign f_gnt     = f_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign f_valid   = f_valid_q;
  assign d_valid   = d_valid_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transaction table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_mem_arbiter;

  localparam int XLEN    = 32;
  localparam int MAXWAIT = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            f_req, flush, d_req, d_we, mem_ready;
  logic [XLEN-1:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic            f_gnt, d_gnt, f_valid, d_valid, mem_req, mem_we, busy;
  logic [XLEN-1:0] f_rdata, d_rdata, mem_addr, mem_wdata;

  int n_pass  = 0;
  int n_total = 0;

  mem_arbiter #(.XLEN(XLEN), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .flush(flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .f_gnt(f_gnt), .d_gnt(d_gnt), .f_valid(f_valid), .d_valid(d_valid),
    .f_rdata(f_rdata), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          fl_g;      // flush together with the request (grant edge)
    bit          fl;        // flush pulse while waiting
    int          delay;     // cycles of mem_ready=0 after the grant cycle
    logic [31:0] rdata;
    bit          exp_valid;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    f_req = 0; d_req = 0; flush = 0; mem_ready = 0; d_we = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, 64'({f_gnt, d_gnt, f_valid, d_valid, mem_req, mem_we, busy}), 64'd0);
    check({name, "_rdata"}, {f_rdata, d_rdata}, 64'd0);
    check({name, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    #1;
    check_all_zero("reset");
    step();
    step();
    reset = 1;
  endtask

  // One complete transaction, driven from a negedge with the arbiter idle.
  task automatic run_txn(input vec_t v);
    if (v.is_d) begin
      d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      f_req = 1; f_addr = v.addr;
    end
    flush = v.fl_g;
    step();
    check("txn_gnt", 64'({f_gnt, d_gnt}), 64'({!v.is_d, v.is_d}));
    check("txn_hdr", 64'({mem_req, mem_we, busy}), 64'({1'b1, v.is_d & v.we, 1'b1}));
    check("txn_addr", 64'(mem_addr), 64'(v.addr));
    if (v.is_d) check("txn_wdata", 64'(mem_wdata), 64'(v.wdata));
    f_req = 0; d_req = 0; flush = v.fl;
    for (int i = 0; i < v.delay; i++) begin
      step();
      flush = 0;
      check("txn_hold", 64'({mem_req, f_valid, d_valid, f_gnt, d_gnt}), 64'b10000);
      check("txn_hold_addr", 64'(mem_addr), 64'(v.addr));
    end
    mem_ready = 1; mem_rdata = v.rdata;
    step();
    mem_ready = 0; flush = 0;
    check("txn_valid", 64'({f_valid, d_valid}),
          64'({!v.is_d & v.exp_valid, v.is_d & v.exp_valid}));
    check("txn_rdata", 64'(v.is_d ? d_rdata : f_rdata), 64'(v.exp_rdata));
    check("txn_done", 64'({mem_req, busy, f_gnt, d_gnt}), 64'd0);
    step();
    check("txn_pulse", 64'({f_valid, d_valid}), 64'd0);
  endtask

  vec_t vecs[10];

  // Randomized-phase reference state (transaction level).
  bit          m_busy, m_isd, m_kill, m_we;
  int          m_streak;
  logic [31:0] m_addr, m_wdata, m_frd, m_drd;

  initial begin
    int outst, ng, nv, k;
    reset = 0;
    idle_inputs();

    // is_d we addr wdata fl_g fl delay rdata exp_valid exp_rdata
    vecs[0] = '{0, 0, 32'h40,  32'h0,        0, 0, 0, 32'h00500093, 1, 32'h00500093};
    vecs[1] = '{1, 0, 32'h200, 32'h0,        0, 0, 2, 32'h11112222, 1, 32'h11112222};
    vecs[2] = '{1, 1, 32'h100, 32'hDEADBEEF, 0, 0, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D};
    vecs[3] = '{0, 0, 32'h44,  32'h0,        0, 1, 4, 32'hBAD0BAD0, 0, 32'h00500093};
    vecs[4] = '{0, 0, 32'h48,  32'h0,        0, 0, 1, 32'h00A00113, 1, 32'h00A00113};
    vecs[5] = '{1, 0, 32'h204, 32'h0,        1, 1, 1, 32'h5555AAAA, 1, 32'h5555AAAA};
    vecs[6] = '{0, 0, 32'h4C,  32'h0,        0, 1, 0, 32'h77777777, 0, 32'h00A00113};
    vecs[7] = '{0, 0, 32'h50,  32'h0,        0, 0, 0, 32'h12345678, 1, 32'h12345678};
    vecs[8] = '{0, 0, 32'h54,  32'h0,        1, 0, 1, 32'hFFFF0000, 0, 32'h12345678};
    vecs[9] = '{0, 0, 32'h58,  32'h0,        0, 0, 2, 32'h0BADF00D, 1, 32'h0BADF00D};

    do_reset();
    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // mem_ready and flush while idle are ignored.
    do_reset();
    mem_ready = 1; flush = 1; mem_rdata = 32'h13579BDF;
    step();
    step();
    check("idle_ready", 64'({f_valid, d_valid, busy, mem_req}), 64'd0);
    check("idle_rdata", {f_rdata, d_rdata}, 64'd0);
    idle_inputs();

    // Simultaneous requests: data first, then fetch.
    do_reset();
    f_req = 1; f_addr = 32'h80;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    step();
    check("both_gnt", 64'({f_gnt, d_gnt}), 64'b01);
    check("both_mem", {31'd0, mem_we, mem_wdata}, {31'd0, 1'b1, 32'hDEADBEEF});
    check("both_addr", 64'(mem_addr), 64'h100);
    d_req = 0; mem_ready = 1; mem_rdata = 32'h0;
    step();
    mem_ready = 0;
    check("both_dvalid", 64'({d_valid, f_gnt}), 64'b10);
    step();
    check("both_fgnt", 64'({f_gnt, mem_we}), 64'b10);
    check("both_faddr", 64'(mem_addr), 64'h80);
    f_req = 0; mem_ready = 1; mem_rdata = 32'h00000013;
    step();
    mem_ready = 0;
    check("both_fvalid", 64'({f_valid, f_rdata}), 64'({1'b1, 32'h00000013}));

    // Starvation limit: DDDF repeating while both requests stay up.
    do_reset();
    f_req = 1; d_req = 1; d_we = 0; f_addr = 32'h60; d_addr = 32'h300;
    for (int g = 0; g < 8; g++) begin
      k = 0;
      do begin
        step();
        k++;
      end while (!f_gnt && !d_gnt && k < 4);
      check("seq_gnt_seen", 64'(f_gnt | d_gnt), 64'd1);
      check("seq_order", 64'({f_gnt, d_gnt}), 64'({g % 4 == 3, g % 4 != 3}));
      mem_ready = 1;
      step();
      mem_ready = 0;
    end
    idle_inputs();

    // Asynchronous reset mid data access.
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h300;
    step();
    d_req = 0;
    check("ar_busy", 64'({busy, d_gnt}), 64'b11);
    step();
    #2;
    reset = 0;
    #1;
    check_all_zero("ar");
    mem_ready = 1; mem_rdata = 32'hAAAA5555;
    step();
    check("ar_novalid", 64'({d_valid, busy}), 64'd0);
    reset = 1;
    step();
    check("ar_after", 64'({d_valid, busy, d_rdata}), 64'd0);
    mem_ready = 0;
    run_txn('{1, 0, 32'h304, 32'h0, 0, 0, 1, 32'h600DDA7A, 1, 32'h600DDA7A});

    // mem_ready stuck high with alternating requesters.
    do_reset();
    mem_ready = 1;
    outst = 0; ng = 0; nv = 0;
    for (int c = 0; c < 40; c++) begin
      d_req = c[0]; f_req = !c[0]; f_addr = 32'(c * 4); d_addr = 32'(c * 8);
      mem_rdata = $urandom;
      step();
      if (f_valid || d_valid) begin outst--; nv++; end
      if (f_gnt || d_gnt) begin outst++; ng++; end
      check("stuck_single", 64'((outst == 0 || outst == 1) && !(f_gnt && d_gnt)
                                && !(f_valid && d_valid)), 64'd1);
    end
    f_req = 0; d_req = 0;
    step();
    if (f_valid || d_valid) nv++;
    step();
    check("stuck_counts", 64'(nv), 64'(ng));
    check("stuck_some", 64'(ng > 10), 64'd1);
    idle_inputs();

    // Randomized traffic against the model.
    do_reset();
    m_busy = 0; m_isd = 0; m_kill = 0; m_we = 0; m_streak = 0;
    m_addr = '0; m_wdata = '0; m_frd = '0; m_drd = '0;
    for (int c = 0; c < 3000; c++) begin
      bit          p_f, p_d, p_we, p_fl, p_rdy;
      logic [31:0] p_fa, p_da, p_wd, p_rd;
      bit          e_fg, e_dg, e_fv, e_dv;
      if (!f_req) begin
        if ($urandom_range(99) < 35) begin f_req = 1; f_addr = $urandom; end
      end else if ($urandom_range(99) < 3) f_req = 0;
      if (!d_req) begin
        if ($urandom_range(99) < 40) begin
          d_req = 1; d_we = $urandom_range(1); d_addr = $urandom; d_wdata = $urandom;
        end
      end else if ($urandom_range(99) < 3) d_req = 0;
      flush = ($urandom_range(99) < 15);
      mem_ready = ($urandom_range(99) < 50);
      mem_rdata = $urandom;
      p_f = f_req; p_d = d_req; p_we = d_we; p_fl = flush; p_rdy = mem_ready;
      p_fa = f_addr; p_da = d_addr; p_wd = d_wdata; p_rd = mem_rdata;
      step();
      e_fg = 0; e_dg = 0; e_fv = 0; e_dv = 0;
      if (!m_busy) begin
        if (p_d && !(p_f && m_streak == MAXWAIT)) begin
          e_dg = 1; m_busy = 1; m_isd = 1; m_we = p_we; m_addr = p_da; m_wdata = p_wd;
          if (p_f) m_streak++;
        end else if (p_f) begin
          e_fg = 1; m_busy = 1; m_isd = 0; m_we = 0; m_addr = p_fa;
          m_streak = 0; m_kill = p_fl;
        end
      end else begin
        if (!m_isd && p_fl) m_kill = 1;
        if (p_rdy) begin
          m_busy = 0;
          if (m_isd) begin e_dv = 1; m_drd = p_rd; end
          else if (!m_kill) begin e_fv = 1; m_frd = p_rd; end
          m_kill = 0;
        end
      end
      check("rnd_ctl", 64'({f_gnt, d_gnt, f_valid, d_valid, mem_req, busy}),
            64'({e_fg, e_dg, e_fv, e_dv, m_busy, m_busy}));
      if (m_busy) begin
        check("rnd_mem", 64'({mem_we, mem_addr}), 64'({m_we, m_addr}));
        if (m_isd) check("rnd_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
      check("rnd_rdata", {f_rdata, d_rdata}, {m_frd, m_drd});
      if (e_fg) f_req = 0;
      if (e_dg) d_req = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
